cart_bus_arbiter: RTL and testbench
===================================

Name: cart_bus_arbiter

Overview:
- Shares the single cart_iface transaction port between two requesters: req0 is the startup screen ROM fetcher, req1 is the link-port loader/debug bridge.
- Sits between the requesters and cart_iface and sequences one read or write at a time.
- Arbitration is round-robin.
- A watchdog aborts transactions that hang.

Parameters:
- AW, 16, cart address width.
- DW, 8, cart data width.
- TIMEOUT_CYCLES, 255, max clk_8m cycles from strobe to transaction completion before abort.

Ports:
- clk_8m  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  req0 transaction pending; held high until req0_done.
- req0_we  input  1  1 = write, 0 = read; stable while valid.
- req0_addr  input  AW  address; stable while valid.
- req0_wdata  input  DW  write data; stable while valid.
- req0_done  output  1  single-cycle completion pulse.
- req0_err  output  1  qualifies req0_done: transaction timed out.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_done, req1_err  same as req0.
- rdata  output  DW  read data, valid in the cycle of either done pulse, held until the next completion.
- cif_addr  output  AW  to cart_iface addr.
- cif_din  output  DW  to cart_iface din.
- cif_rd  output  1  single-cycle read strobe.
- cif_wr  output  1  single-cycle write strobe.
- cif_dout  input  DW  from cart_iface dout.
- cif_busy  input  1  from cart_iface busy.

Behaviour:
- Clock and reset: one clock, clk_8m. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0; state IDLE; rr_last = 1, so req0 wins the first tie.
- State machine:
  - IDLE: if cif_busy = 0 and any valid is high, grant one requester and go to ISSUE. If both are valid, grant the one that is not rr_last. Latch grant, addr, wdata and we into internal registers; cif_addr/cif_din drive from these registers.
  - ISSUE (1 cycle): assert cif_rd (we = 0) or cif_wr (we = 1); clear the timer; go to WAIT_BUSY.
  - WAIT_BUSY: wait for cif_busy = 1, then go to WAIT_DONE. If cif_busy is already 1 on entry, go to WAIT_DONE in the next cycle.
  - WAIT_DONE: on cif_busy = 0, capture cif_dout into rdata (reads only; writes leave rdata unchanged), go to RESP.
  - RESP (1 cycle): pulse the granted reqN_done; set rr_last = granted index; go to IDLE.
- Timer: increments every cycle in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_CYCLES, go to RESP with reqN_err = 1; rdata is unchanged.
- Latency: read with cif_busy high for B cycles gives done exactly 3 + B cycles after the IDLE grant cycle, minimum 4.
- Back-to-back grants: earliest next grant is the cycle after RESP, so there is one idle-state cycle between transactions.
- Latched fields: requester inputs are sampled only at grant. Changes while in flight are ignored.
- Drop-out: if the granted requester drops valid mid-transaction, the transaction still completes and done still pulses. The requester must ignore it.
- Mutual exclusion: never more than one done pulse per cycle; cif_rd and cif_wr are never both high.
- Timer width: $clog2(TIMEOUT_CYCLES+1); no wrap.
- Reset mid-transaction: outputs are 0 immediately and no done is issued. cart_iface is reset by its own reset.

Optional Feature:
- Macro: CART_ARB_LOCK_EN.
- Enabled:
  - Adds input ports req0_lock and req1_lock (1 bit each).
  - If the granted requester has lock = 1 in RESP, it keeps ownership. IDLE then grants only that requester until it presents valid with lock = 0 or drops lock while idle.
  - The watchdog also releases the lock.
  - Used for multi-byte MBC bank-switch sequences.
- Disabled: the ports do not exist and pure round-robin applies.

Decomposition:
- Package cart_bus_pkg:
  - typedef for the state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP);
  - CART_AW / CART_DW constants;
  - request struct {we, addr, wdata}.
- One sub-module, cart_arb_rr2: combinational 2-way round-robin picker with inputs valid[1:0] and last, outputs gnt_idx and any.

Test Plan:
1. Single read: req0 read addr 16'h0104; cart_iface model busy for 5 cycles, returns 8'hCE -> one cif_rd pulse with cif_addr = 16'h0104; req0_done 8 cycles after grant; rdata = 8'hCE; req0_err = 0.
2. Contention: req0 and req1 valid in the same cycle, each reissuing 3 times after done -> grant order 0,1,0,1,0,1; no overlapping strobes.
3. Write: req1 write 8'h01 to 16'h2000 -> one cif_wr pulse with cif_din = 8'h01; rdata unchanged from the previous value.
4. Timeout: TIMEOUT_CYCLES = 16, busy held high forever -> req0_done with req0_err = 1, 16 cycles after ISSUE; arbiter then serves a pending req1 normally.
5. Async reset: assert rst_n = 0 in WAIT_DONE -> cif_rd/cif_wr/done are 0 immediately; after release, the first contention grants req0.
6. CART_ARB_LOCK_EN: req1 lock = 1 for 3 writes while req0 is continuously valid -> all 3 go to req1; req0 is granted only after req1's unlocked access.

Source files
------------

// File: rtl/cart_bus_pkg.sv
// -----------------------------------------------------------------------------
// cart_bus_pkg
// Shared types and constants for the cartridge bus arbiter.
//   - CART_AW / CART_DW : cartridge address / data widths
//   - arb_state_e       : arbiter FSM state encoding
//   - cart_req_t        : request fields latched at grant time
// -----------------------------------------------------------------------------
package cart_bus_pkg;

  localparam int CART_AW = 16;
  localparam int CART_DW = 8;

  // Legacy-compatible raw encodings; the enum below takes its values from these.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    ISSUE     = S_ISSUE,
    WAIT_BUSY = S_WAIT_BUSY,
    WAIT_DONE = S_WAIT_DONE,
    RESP      = S_RESP
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [CART_AW-1:0] addr;
    logic [CART_DW-1:0] wdata;
  } cart_req_t;

endpackage

// File: rtl/cart_arb_rr2.sv
// -----------------------------------------------------------------------------
// cart_arb_rr2
// Combinational 2-way round-robin picker.
//   i_valid[1:0] : pending requests
//   i_last       : index served most recently (loses a tie)
//   o_gnt_idx    : index to grant (meaningful only when o_any = 1)
//   o_any        : at least one request pending
// -----------------------------------------------------------------------------
module cart_arb_rr2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic       o_gnt_idx,
  output logic       o_any
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_any     = |i_valid;
    o_gnt_idx = 1'b0;
    unique case (i_valid)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = ~i_last;
      default: o_gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cart_bus_arbiter
// Shares the single cart_iface transaction port between req0 (startup screen
// ROM fetcher) and req1 (link-port loader / debug bridge). One read or write
// is in flight at a time; grants alternate round-robin; a watchdog aborts a
// transaction that does not complete within TIMEOUT_CYCLES of its strobe.
//
// Ports:
//   clk_8m, rst_n                  clock, async active-low reset
//   reqN_valid/we/addr/wdata       request N (held until reqN_done)
//   reqN_done, reqN_err            completion pulse, timeout qualifier
//   rdata                          last read data, held between completions
//   cif_addr/din/rd/wr             to cart_iface
//   cif_dout/busy                  from cart_iface
//   reqN_lock                      (CART_ARB_LOCK_EN only) keep ownership
//
// Build option: define CART_ARB_LOCK_EN to add req0_lock/req1_lock. A granted
// requester holding lock in the response cycle keeps the bus until it issues
// an unlocked access, drops lock while idle, or a watchdog abort occurs.
//
// AW/DW must match CART_AW/CART_DW: the latched request uses cart_req_t.
// TIMEOUT_CYCLES must be at least 2.
// -----------------------------------------------------------------------------
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int AW             = CART_AW,
  parameter int DW             = CART_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_8m,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
`ifdef CART_ARB_LOCK_EN
  input  logic          req0_lock,
  input  logic          req1_lock,
`endif
  output logic          req0_done,
  output logic          req0_err,
  output logic          req1_done,
  output logic          req1_err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] cif_addr,
  output logic [DW-1:0] cif_din,
  output logic          cif_rd,
  output logic          cif_wr,
  input  logic [DW-1:0] cif_dout,
  input  logic          cif_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The timer holds k-1 in the k-th cycle after the strobe. Deciding to abort
  // when it holds TIMEOUT_CYCLES-2 lands RESP exactly TIMEOUT_CYCLES cycles
  // after the strobe.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

  arb_state_e    r_state;
  cart_req_t     r_req;
  logic          r_gnt;
  logic          r_rr_last;
  logic          r_err;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_rdata;

  logic [1:0]    w_valid;
  logic          w_gnt_idx;
  logic          w_any;
  logic          w_timeout;

`ifdef CART_ARB_LOCK_EN
  logic r_locked;
  logic r_lock_owner;
  logic w_owner_valid;
  logic w_owner_lock;
  logic w_gnt_lock;

  assign w_owner_valid = r_lock_owner ? req1_valid : req0_valid;
  assign w_owner_lock  = r_lock_owner ? req1_lock  : req0_lock;
  assign w_gnt_lock    = r_gnt        ? req1_lock  : req0_lock;

  // While locked, only the owner is visible to the picker.
  assign w_valid = !r_locked    ? {req1_valid, req0_valid} :
                   r_lock_owner ? {req1_valid, 1'b0}       :
                                  {1'b0, req0_valid};

  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      r_locked     <= 1'b0;
      r_lock_owner <= 1'b0;
    end else if (r_state == RESP) begin
      // An aborted transaction never leaves the bus locked.
      r_locked     <= w_gnt_lock && !r_err;
      r_lock_owner <= r_gnt;
    end else if (r_state == IDLE && r_locked && !w_owner_valid && !w_owner_lock) begin
      r_locked <= 1'b0;
    end
  end
`else
  assign w_valid = {req1_valid, req0_valid};
`endif

  cart_arb_rr2 u_rr (
    .i_valid   (w_valid),
    .i_last    (r_rr_last),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_timeout = (r_timer == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_gnt     <= 1'b0;
      r_rr_last <= 1'b1;
      r_err     <= 1'b0;
      r_timer   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!cif_busy && w_any) begin
            r_gnt   <= w_gnt_idx;
            r_req   <= w_gnt_idx ? '{we: req1_we, addr: req1_addr, wdata: req1_wdata}
                                 : '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_timer <= '0;
          r_err   <= 1'b0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!w_timeout) r_timer <= r_timer + TW'(1);
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (cif_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!w_timeout) r_timer <= r_timer + TW'(1);
          // A completion seen in the same cycle as the abort decision wins.
          if (!cif_busy) begin
            if (!r_req.we) r_rdata <= cif_dout;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_rr_last <= r_gnt;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes and done pulses decode from state, so an async reset clears
  // them in the same instant it forces IDLE.
  assign cif_rd    = (r_state == ISSUE) && !r_req.we;
  assign cif_wr    = (r_state == ISSUE) &&  r_req.we;
  assign cif_addr  = r_req.addr;
  assign cif_din   = r_req.wdata;
  assign rdata     = r_rdata;
  assign req0_done = (r_state == RESP) && !r_gnt;
  assign req1_done = (r_state == RESP) &&  r_gnt;
  assign req0_err  = req0_done && r_err;
  assign req1_err  = req1_done && r_err;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cart_bus_arbiter
// Directed bench for cart_bus_arbiter (TIMEOUT_CYCLES = 16) with a small
// cart_iface model: a strobe raises busy for busy_len cycles (or until
// hold_busy clears) and read data is addr[7:0] ^ 8'hCA. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// Define CART_ARB_LOCK_EN to build the bus-lock variant and its directed steps.
// -----------------------------------------------------------------------------
module tb_cart_bus_arbiter;

  logic        clk_8m;
  logic        rst_n;
  logic        req0_valid, req0_we;
  logic [15:0] req0_addr;
  logic [7:0]  req0_wdata;
  logic        req1_valid, req1_we;
  logic [15:0] req1_addr;
  logic [7:0]  req1_wdata;
  logic        req0_lock, req1_lock;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [7:0]  rdata;
  logic [15:0] cif_addr;
  logic [7:0]  cif_din;
  logic        cif_rd, cif_wr;
  logic [7:0]  cif_dout;
  logic        cif_busy;

  int n_tests = 0;
  int n_fail  = 0;

  cart_bus_arbiter #(.AW(16), .DW(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_8m     (clk_8m),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
`ifdef CART_ARB_LOCK_EN
    .req0_lock  (req0_lock),
    .req1_lock  (req1_lock),
`endif
    .req0_done  (req0_done),
    .req0_err   (req0_err),
    .req1_done  (req1_done),
    .req1_err   (req1_err),
    .rdata      (rdata),
    .cif_addr   (cif_addr),
    .cif_din    (cif_din),
    .cif_rd     (cif_rd),
    .cif_wr     (cif_wr),
    .cif_dout   (cif_dout),
    .cif_busy   (cif_busy)
  );

  initial begin
    clk_8m = 1'b0;
    forever #5 clk_8m = ~clk_8m;
  end

  // ---------------- cart_iface model ----------------
  int   busy_len  = 5;
  logic hold_busy = 1'b0;
  int   bcnt;

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return a[7:0] ^ 8'hCA;
  endfunction

  always @(posedge clk_8m or negedge rst_n) begin
    if (!rst_n) begin
      cif_busy <= 1'b0;
      cif_dout <= 8'h00;
      bcnt     <= 0;
    end else if (cif_rd || cif_wr) begin
      cif_busy <= 1'b1;
      bcnt     <= busy_len - 1;
      if (cif_rd) cif_dout <= model_rd(cif_addr);
    end else if (cif_busy) begin
      if (bcnt > 0)        bcnt     <= bcnt - 1;
      else if (!hold_busy) cif_busy <= 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, excl_viol = 0;
  logic [15:0] strobe_addr = '0;
  logic [7:0]  strobe_din  = '0;

  always @(posedge clk_8m) begin
    if (cif_rd) begin
      rd_cnt      <= rd_cnt + 1;
      strobe_addr <= cif_addr;
    end
    if (cif_wr) begin
      wr_cnt      <= wr_cnt + 1;
      strobe_addr <= cif_addr;
      strobe_din  <= cif_din;
    end
    if ((cif_rd && cif_wr) || (req0_done && req1_done)) excl_viol <= excl_viol + 1;
    if (req0_done || req1_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Steps falling edges until a done pulse; lat counts edges from the call.
  task automatic wait_done(input int budget, output int who, output int lat, output logic err);
    who = -1;
    lat = 0;
    err = 1'b0;
    while (who < 0 && lat < budget) begin
      @(negedge clk_8m);
      lat++;
      if (req0_done)      begin who = 0; err = req0_err; end
      else if (req1_done) begin who = 1; err = req1_err; end
    end
    check("done_within_budget", (who >= 0), 1);
  endtask

  int          who, lat, rd0, wr0, dc0, n0, n1;
  logic        err;
  logic [7:0]  prev_rdata;
  logic [15:0] a0, a1;

  initial begin
    rst_n      = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0; req0_lock = 0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; req1_lock = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk_8m);
    check("rst_req0_done", req0_done, 0);
    check("rst_req1_done", req1_done, 0);
    check("rst_req0_err",  req0_err,  0);
    check("rst_req1_err",  req1_err,  0);
    check("rst_cif_rd",    cif_rd,    0);
    check("rst_cif_wr",    cif_wr,    0);
    check("rst_cif_addr",  cif_addr,  0);
    check("rst_rdata",     rdata,     0);
    rst_n = 1'b1;

    // ---- 1: single read, busy 5 cycles ----
    @(negedge clk_8m);
    rd0 = rd_cnt; wr0 = wr_cnt; busy_len = 5;
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0104;
    wait_done(30, who, lat, err);
    req0_valid = 0;
    check("t1_who",         who, 0);
    check("t1_latency",     lat, 8);
    check("t1_err",         err, 0);
    check("t1_rdata",       rdata, 8'hCE);
    check("t1_rd_pulses",   rd_cnt - rd0, 1);
    check("t1_wr_pulses",   wr_cnt - wr0, 0);
    check("t1_strobe_addr", strobe_addr, 16'h0104);

    // ---- 3: write from req1 ----
    @(negedge clk_8m);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req1_valid = 1; req1_we = 1; req1_addr = 16'h2000; req1_wdata = 8'h01;
    wait_done(30, who, lat, err);
    req1_valid = 0;
    check("t3_who",         who, 1);
    check("t3_latency",     lat, 8);
    check("t3_err",         err, 0);
    check("t3_wr_pulses",   wr_cnt - wr0, 1);
    check("t3_rd_pulses",   rd_cnt - rd0, 0);
    check("t3_strobe_addr", strobe_addr, 16'h2000);
    check("t3_strobe_din",  strobe_din, 8'h01);
    check("t3_rdata_held",  rdata, 8'hCE);

    // ---- 2: contention, 3 reissues each, req1 served last ----
    @(negedge clk_8m);
    busy_len = 2; n0 = 0; n1 = 0;
    a0 = 16'h0010; a1 = 16'h0021;
    req0_valid = 1; req0_we = 0; req0_addr = a0;
    req1_valid = 1; req1_we = 0; req1_addr = a1;
    for (int i = 0; i < 6; i++) begin
      wait_done(20, who, lat, err);
      check("t2_rr_order", who, i % 2);
      check("t2_rdata", rdata, model_rd((who == 1) ? a1 : a0));
      if (who == 0) begin n0++; if (n0 == 3) req0_valid = 0; end
      if (who == 1) begin n1++; if (n1 == 3) req1_valid = 0; end
    end
    check("t2_exclusion", excl_viol, 0);
    prev_rdata = model_rd(a1);

    // ---- 4: timeout with busy stuck, then req1 served ----
    @(negedge clk_8m);
    hold_busy = 1'b1;
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0300;
    req1_valid = 1; req1_we = 0; req1_addr = 16'h0400;
    wait_done(40, who, lat, err);
    hold_busy = 1'b0; req0_valid = 0;
    check("t4_who",        who, 0);
    check("t4_latency",    lat, 17);
    check("t4_err",        err, 1);
    check("t4_rdata_held", rdata, prev_rdata);
    wait_done(30, who, lat, err);
    req1_valid = 0;
    check("t4_next_who",     who, 1);
    check("t4_next_latency", lat, 6);
    check("t4_next_err",     err, 0);
    check("t4_next_rdata",   rdata, model_rd(16'h0400));

    // ---- 5: async reset in WAIT_DONE ----
    @(negedge clk_8m);
    busy_len = 5;
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0555;
    repeat (3) @(negedge clk_8m);
    #1 rst_n = 1'b0;
    req1_valid = 1; req1_we = 0; req1_addr = 16'h0666;
    #1;
    check("t5_cif_rd",   cif_rd, 0);
    check("t5_cif_wr",   cif_wr, 0);
    check("t5_done0",    req0_done, 0);
    check("t5_done1",    req1_done, 0);
    check("t5_cif_addr", cif_addr, 0);
    check("t5_rdata",    rdata, 0);
    dc0 = done_cnt;
    repeat (3) @(negedge clk_8m);
    check("t5_no_done_in_reset", done_cnt - dc0, 0);
    rst_n = 1'b1;
    wait_done(30, who, lat, err);
    req0_valid = 0; req1_valid = 0;
    check("t5_first_grant", who, 0);
    check("t5_rdata_after", rdata, model_rd(16'h0555));

`ifdef CART_ARB_LOCK_EN
    // ---- 6: req1 locked writes while req0 waits ----
    @(negedge clk_8m);
    busy_len = 2; n1 = 0;
    req0_valid = 1; req0_we = 0; req0_addr = 16'h0010;
    req1_valid = 1; req1_we = 1; req1_addr = 16'h2000; req1_wdata = 8'h05; req1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      wait_done(20, who, lat, err);
      check("t6_lock_order", who, (i < 4) ? 1 : 0);
      if (who == 1) begin
        n1++;
        if (n1 == 3) begin
          @(negedge clk_8m);
          req1_lock = 0;
        end
        if (n1 == 4) req1_valid = 0;
      end
      if (who == 0) req0_valid = 0;
    end
    req0_valid = 0; req1_valid = 0;
`endif

    check("final_exclusion", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
